// File: rtl/bram_pattern_writer_checker.sv
// ============================================================================
// bram_pattern_writer_checker : write/read-back pattern self-test for one 256x16 block RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module bram_pattern_writer_checker #(
   parameter logic [7:0]  LAST_ADDRESS = 8'd255,
   parameter logic [15:0] SEED         = 16'ha50f,
   parameter int          READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] error_count,
   output logic [7:0]  first_error_address,
   output logic [7:0]  write_address,
   output logic [15:0] write_data,
   output logic        write_enable,
   output logic [7:0]  read_address,
   output logic        read_enable,
   input  logic [15:0] read_data
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);

   state_t            state;
   state_t            state_next;
   logic [7:0]        address;
   logic [1:0]        drain_count;
   logic              launch;
   logic              mismatch;
   logic [READ_LATENCY-1:0] pipe_valid;
   logic [7:0]        pipe_address [READ_LATENCY];

   function automatic logic [15:0] pattern(input logic [7:0] a);
      return SEED ^ {a, ~a};
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Outputs decode from state so an asynchronous reset silences the RAM ports at once.
   always_comb begin
      state_next    = state;
      busy          = 1'b0;
      done          = 1'b0;
      write_enable  = 1'b0;
      write_address = 8'd0;
      write_data    = 16'd0;
      read_enable   = 1'b0;
      read_address  = 8'd0;
      case (state)
         IDLE: if (start) state_next = WRITE;
         WRITE: begin
            busy          = 1'b1;
            write_enable  = 1'b1;
            write_address = address;
            write_data    = pattern(address);
            if (address == LAST_ADDRESS) state_next = READ;
         end
         READ: begin
            busy         = 1'b1;
            read_enable  = 1'b1;
            read_address = address;
            if (address == LAST_ADDRESS) state_next = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_count == DRAIN_LAST) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_next = WRITE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign pass     = (state == DONE) && (error_count == 16'd0);
   assign launch   = ((state == IDLE) || (state == DONE)) && start;
   assign mismatch = pipe_valid[READ_LATENCY-1] &&
                     (read_data != pattern(pipe_address[READ_LATENCY-1]));

   // Terminal count is an explicit compare so LAST_ADDRESS=255 never wraps into an extra access.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         address     <= 8'd0;
         drain_count <= 2'd0;
      end else begin
         drain_count <= (state == DRAIN) ? drain_count + 2'd1 : 2'd0;
         case (state)
            WRITE:   address <= (address == LAST_ADDRESS) ? 8'd0 : address + 8'd1;
            READ:    address <= address + 8'd1;
            default: address <= 8'd0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pipe_valid <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pipe_address[i] <= 8'd0;
      end else begin
         pipe_valid[0]   <= read_enable;
         pipe_address[0] <= read_address;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i]   <= pipe_valid[i-1];
            pipe_address[i] <= pipe_address[i-1];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         error_count         <= 16'd0;
         first_error_address <= 8'd0;
      end else if (launch) begin
         error_count         <= 16'd0;
         first_error_address <= 8'd0;
      end else if (mismatch) begin
         if (error_count == 16'd0)    first_error_address <= pipe_address[READ_LATENCY-1];
         if (error_count != 16'hffff) error_count         <= error_count + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bram_pattern_writer_checker.sv
// ============================================================================
// tb_bram_pattern_writer_checker : directed scoreboard bench with behavioural RAM models
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bram_pattern_writer_checker;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n;
   int   total  = 0;
   int   passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] pat(input logic [7:0] a);
      return 16'ha50f ^ {a, ~a};
   endfunction

   // Instance A: 256 words, latency 1
   logic        start_a, busy_a, done_a, pass_a, we_a, re_a;
   logic [15:0] err_a, wd_a, rd_a;
   logic [7:0]  first_a, wa_a, ra_a;
   int          mode_a;
   logic [15:0] mem_a [256];

   bram_pattern_writer_checker dut_a (
      .clock(clock), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .error_count(err_a), .first_error_address(first_a),
      .write_address(wa_a), .write_data(wd_a), .write_enable(we_a),
      .read_address(ra_a), .read_enable(re_a), .read_data(rd_a)
   );

   always @(posedge clock) begin
      if (we_a) mem_a[wa_a] <= wd_a;
      if (re_a) begin
         case (mode_a)
            1:       rd_a <= mem_a[ra_a] ^ ((ra_a == 8'h99) ? 16'h0001 : 16'h0000);
            2:       rd_a <= 16'h0000;
            default: rd_a <= mem_a[ra_a];
         endcase
      end
   end

   // Instance B: 4 words, latency 2
   logic        start_b, busy_b, done_b, pass_b, we_b, re_b;
   logic [15:0] err_b, wd_b, rd_b, rq1_b;
   logic [7:0]  first_b, wa_b, ra_b;
   logic [15:0] mem_b [256];

   bram_pattern_writer_checker #(.LAST_ADDRESS(8'd3), .SEED(16'ha50f), .READ_LATENCY(2)) dut_b (
      .clock(clock), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .error_count(err_b), .first_error_address(first_b),
      .write_address(wa_b), .write_data(wd_b), .write_enable(we_b),
      .read_address(ra_b), .read_enable(re_b), .read_data(rd_b)
   );

   always @(posedge clock) begin
      if (we_b) mem_b[wa_b] <= wd_b;
      if (re_b) rq1_b <= mem_b[ra_b];
      rd_b <= rq1_b;
   end

   // Scoreboard queues: loaded when start is driven, drained as the DUTs access their RAMs
   logic [23:0] exp_w_a [$];
   logic [7:0]  exp_r_a [$];
   logic [23:0] exp_w_b [$];
   logic [7:0]  exp_r_b [$];
   int          writes_a, reads_a, writes_b, reads_b;
   logic [15:0] wd45;

   always @(negedge clock) begin
      if (we_a) begin
         writes_a++;
         if (wa_a == 8'h45) wd45 = wd_a;
         if (exp_w_a.size() == 0) chk("a_write_extra", 32'(exp_w_a.size()), 32'd1);
         else chk("a_write", {8'h0, wa_a, wd_a}, {8'h0, exp_w_a.pop_front()});
      end
      if (re_a) begin
         reads_a++;
         if (exp_r_a.size() == 0) chk("a_read_extra", 32'(exp_r_a.size()), 32'd1);
         else chk("a_read_addr", {24'h0, ra_a}, {24'h0, exp_r_a.pop_front()});
      end
      if (we_b) begin
         writes_b++;
         if (exp_w_b.size() == 0) chk("b_write_extra", 32'(exp_w_b.size()), 32'd1);
         else chk("b_write", {8'h0, wa_b, wd_b}, {8'h0, exp_w_b.pop_front()});
      end
      if (re_b) begin
         reads_b++;
         if (exp_r_b.size() == 0) chk("b_read_extra", 32'(exp_r_b.size()), 32'd1);
         else chk("b_read_addr", {24'h0, ra_b}, {24'h0, exp_r_b.pop_front()});
      end
   end

   task automatic load_a();
      exp_w_a.delete();
      exp_r_a.delete();
      for (int a = 0; a < 256; a++) begin
         exp_w_a.push_back({8'(a), pat(8'(a))});
         exp_r_a.push_back(8'(a));
      end
      writes_a = 0;
      reads_a  = 0;
   endtask

   // Pulses start, then counts edges after E0 until done; p1/p2 inject extra start pulses.
   task automatic run_a(input int p1, input int p2, output int lat);
      load_a();
      start_a = 1'b1;
      @(negedge clock);
      start_a = 1'b0;
      lat = 0;
      while (!done_a && lat < 2000) begin
         @(negedge clock);
         lat++;
         start_a = (lat == p1 || lat == p2) ? 1'b1 : 1'b0;
      end
      start_a = 1'b0;
   endtask

   int lat;

   initial begin
      reset_n = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      mode_a  = 0;
      wd45    = 16'h0;
      writes_a = 0; reads_a = 0; writes_b = 0; reads_b = 0;
      repeat (2) @(negedge clock);
      chk("rst_busy", {31'h0, busy_a}, 32'd0);
      chk("rst_done", {31'h0, done_a}, 32'd0);
      chk("rst_pass", {31'h0, pass_a}, 32'd0);
      chk("rst_err", {16'h0, err_a}, 32'd0);
      chk("rst_first", {24'h0, first_a}, 32'd0);
      chk("rst_ports", {wa_a, ra_a, we_a, re_a, 14'h0}, 32'd0);
      chk("rst_wdata", {16'h0, wd_a}, 32'd0);
      chk("rst_b_outs", {busy_b, done_b, pass_b, we_b, re_b, 27'h0}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Good RAM, full address range
      run_a(0, 0, lat);
      chk("t1_latency", 32'(lat), 32'd513);
      chk("t1_pass", {31'h0, pass_a}, 32'd1);
      chk("t1_err", {16'h0, err_a}, 32'd0);
      chk("t1_first", {24'h0, first_a}, 32'd0);
      chk("t1_writes", 32'(writes_a), 32'd256);
      chk("t1_reads", 32'(reads_a), 32'd256);
      chk("t1_queues", 32'(exp_w_a.size() + exp_r_a.size()), 32'd0);
      chk("t1_wdata_45", {16'h0, wd45}, 32'h0000e0b5);
      chk("t1_busy", {31'h0, busy_a}, 32'd0);
      repeat (3) @(negedge clock);
      chk("t1_done_hold", {31'h0, done_a}, 32'd1);
      chk("t1_ports_idle", {30'h0, we_a, re_a}, 32'd0);

      // One corrupted word
      mode_a = 1;
      run_a(0, 0, lat);
      chk("t2_latency", 32'(lat), 32'd513);
      chk("t2_pass", {31'h0, pass_a}, 32'd0);
      chk("t2_err", {16'h0, err_a}, 32'd1);
      chk("t2_first", {24'h0, first_a}, 32'h99);

      // Every word reads as zero
      mode_a = 2;
      run_a(0, 0, lat);
      chk("t3_err", {16'h0, err_a}, 32'd256);
      chk("t3_first", {24'h0, first_a}, 32'h00);
      chk("t3_pass", {31'h0, pass_a}, 32'd0);

      // Reset mid-READ
      mode_a = 0;
      load_a();
      start_a = 1'b1;
      @(negedge clock);
      start_a = 1'b0;
      repeat (300) @(negedge clock);
      chk("t4_reading", {30'h0, busy_a, re_a}, 32'd3);
      reset_n = 1'b0;
      #1;
      chk("t4_we", {31'h0, we_a}, 32'd0);
      chk("t4_re", {31'h0, re_a}, 32'd0);
      chk("t4_busy", {31'h0, busy_a}, 32'd0);
      chk("t4_done", {31'h0, done_a}, 32'd0);
      chk("t4_err", {16'h0, err_a}, 32'd0);
      @(negedge clock);
      exp_w_a.delete();
      exp_r_a.delete();
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      chk("t4_idle", {30'h0, busy_a, done_a}, 32'd0);
      chk("t4_idle_ports", {30'h0, we_a, re_a}, 32'd0);
      run_a(0, 0, lat);
      chk("t4_rerun_latency", 32'(lat), 32'd513);
      chk("t4_rerun_pass", {31'h0, pass_a}, 32'd1);

      // start pulses while busy are ignored
      run_a(100, 400, lat);
      chk("t5_latency", 32'(lat), 32'd513);
      chk("t5_writes", 32'(writes_a), 32'd256);
      chk("t5_reads", 32'(reads_a), 32'd256);
      chk("t5_pass", {31'h0, pass_a}, 32'd1);

      // Short range with two-cycle read latency
      exp_w_b.delete();
      exp_r_b.delete();
      for (int a = 0; a < 4; a++) begin
         exp_w_b.push_back({8'(a), pat(8'(a))});
         exp_r_b.push_back(8'(a));
      end
      writes_b = 0;
      reads_b  = 0;
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      lat = 0;
      while (!done_b && lat < 200) begin
         @(negedge clock);
         lat++;
      end
      chk("t6_latency", 32'(lat), 32'd10);
      chk("t6_writes", 32'(writes_b), 32'd4);
      chk("t6_reads", 32'(reads_b), 32'd4);
      chk("t6_pass", {31'h0, pass_b}, 32'd1);
      chk("t6_err", {16'h0, err_b}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
